// File: rtl/contador_sched.sv
// contador_sched: grants a shared up-counter to one of N_REQ requesters per job (count 0..target).
// Round-robin arbitration by default; define CONTADOR_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins).
module contador_sched #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] tgt,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [CNT_W-1:0]       contador,
  output logic                   busy
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state, state_n;
  logic [N_REQ-1:0] gnt_n, done_n;
  logic [CNT_W-1:0] cnt_n, tgt_q, tgt_n;
  logic             busy_n;
  logic [IDX_W-1:0] owner, owner_n, win, start;
  logic             found;
  int unsigned      idx;
  logic [CNT_W-1:0] tgt_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign tgt_a[g] = tgt[g*CNT_W +: CNT_W];
  end

`ifdef CONTADOR_SCHED_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] ptr, ptr_n;
  assign start = ptr;
`endif

  // First requesting index scanning upward (with wrap) from start.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(start) + i) % N_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    cnt_n   = contador;
    busy_n  = busy;
    tgt_n   = tgt_q;
    owner_n = owner;
`ifndef CONTADOR_SCHED_FIXED_PRIO_EN
    ptr_n   = ptr;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n    = COUNT;
          tgt_n      = tgt_a[win];
          cnt_n      = '0;
          gnt_n      = '0;
          gnt_n[win] = 1'b1;
          busy_n     = 1'b1;
          owner_n    = win;
`ifndef CONTADOR_SCHED_FIXED_PRIO_EN
          ptr_n      = (32'(win) == N_REQ - 1) ? '0 : win + IDX_W'(1);
`endif
        end
      end
      COUNT: begin
        if (!req[owner]) begin
          // Abort: release without a completion pulse; counter holds.
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
        end else if (contador == tgt_q) begin
          state_n       = DONE;
          gnt_n         = '0;
          done_n[owner] = 1'b1;
        end else begin
          cnt_n = contador + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      done     <= '0;
      contador <= '0;
      busy     <= 1'b0;
      tgt_q    <= '0;
      owner    <= '0;
`ifndef CONTADOR_SCHED_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      done     <= done_n;
      contador <= cnt_n;
      busy     <= busy_n;
      tgt_q    <= tgt_n;
      owner    <= owner_n;
`ifndef CONTADOR_SCHED_FIXED_PRIO_EN
      ptr      <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_contador_sched.sv
// Directed bench for contador_sched; completion pulses are checked against a queue of expected jobs.
module tb_contador_sched;
  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] tgt;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   contador;
  logic           busy;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  typedef struct packed {
    logic [N-1:0] d;
    logic [W-1:0] c;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  contador_sched #(.N_REQ(N), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .tgt(tgt),
    .gnt(gnt), .done(done), .contador(contador), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_tgt(input int i, input logic [W-1:0] v);
    tgt = (tgt & ~(16'hF << (i * 4))) | (16'(v) << (i * 4));
  endtask

  task automatic expect_done(input logic [N-1:0] d, input logic [W-1:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  function automatic int held_winner(input int j);
`ifdef CONTADOR_SCHED_FIXED_PRIO_EN
    return 0 + (j & 0);
`else
    return j % 2;
`endif
  endfunction

  // Scoreboard: each completion pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!reset && done != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_vec", 32'(done), 32'(mon_e.d));
        check("done_cnt", 32'(contador), 32'(mon_e.c));
        check("done_gnt_excl", 32'(gnt), 0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    tgt   = '0;
    tick(2);
    check("rst_outputs", 32'({gnt, done, contador, busy}), 0);
    reset = 1'b0;

    // Single job, target 5
    set_tgt(0, 5);
    req = 4'b0001;
    tick(1);
    check("single_grant", 32'({gnt, contador}), 'h10);
    check("single_busy", 32'(busy), 1);
    expect_done(4'b0001, 4'd5);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("single_cnt", 32'({gnt, contador}), 'h10 + k);
    end
    tick(1);
    check("single_done_gnt", 32'({gnt, busy}), 1);
    req = '0;
    tick(1);
    check("single_idle", 32'({done, contador, busy}), 'h0A);

    // Target 0
    set_tgt(1, 0);
    req = 4'b0010;
    tick(1);
    check("t0_grant", 32'({gnt, contador}), 'h20);
    expect_done(4'b0010, 4'd0);
    tick(1);
    check("t0_done_cycle", 32'({gnt, contador}), 0);
    req = '0;
    tick(1);
    check("t0_idle", 32'({done, busy}), 0);

    // Target 15, no wrap
    set_tgt(2, 15);
    req = 4'b0100;
    tick(1);
    check("t15_grant", 32'({gnt, contador}), 'h40);
    expect_done(4'b0100, 4'd15);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      check("t15_cnt", 32'({gnt, contador}), 'h40 + k);
    end
    tick(1);
    check("t15_done_cycle", 32'({gnt, contador}), 'h0F);
    req = '0;
    tick(1);
    check("t15_idle", 32'({done, contador, busy}), 'h1E);

    // Abort at contador=2, target 9
    set_tgt(2, 9);
    req = 4'b0100;
    tick(1);
    check("abort_grant", 32'({gnt, contador}), 'h40);
    tick(2);
    check("abort_cnt2", 32'({gnt, contador}), 'h42);
    req = '0;
    tick(1);
    check("abort_release", 32'({gnt, done, contador, busy}), 'h04);
    tick(2);
    check("abort_stays_idle", 32'({gnt, done, contador, busy}), 'h04);

    // Target change during job is ignored
    set_tgt(1, 7);
    req = 4'b0010;
    tick(1);
    check("tchg_grant", 32'({gnt, contador}), 'h20);
    tick(1);
    set_tgt(1, 3);
    expect_done(4'b0010, 4'd7);
    tick(6);
    check("tchg_past_new", 32'({gnt, contador}), 'h27);
    tick(1);
    check("tchg_done_cycle", 32'({gnt, contador}), 'h07);
    req = '0;
    tick(1);

    // Reset mid-job at contador=3
    set_tgt(0, 5);
    req = 4'b0001;
    tick(1);
    check("rstmid_grant", 32'({gnt, contador}), 'h10);
    tick(3);
    check("rstmid_cnt3", 32'({gnt, contador}), 'h13);
    reset = 1'b1;
    #1;
    check("rstmid_async", 32'({gnt, done, contador, busy}), 0);
    tgt = 16'h1111;
    req = 4'b1111;
    tick(1);
    reset = 1'b0;

    // All four request, each drops after its done: order 0,1,2,3
    for (int j = 0; j < 4; j++) begin
      tick(1);
      check("rr_grant", 32'({gnt, contador}), (1 << j) << 4);
      expect_done(4'(1 << j), 4'd1);
      tick(2);
      check("rr_done_cycle", 32'(gnt), 0);
      req[j] = 1'b0;
      tick(1);
      check("rr_idle", 32'(busy), 0);
    end

    // Two requests held, target 0
    set_tgt(0, 0);
    set_tgt(1, 0);
    req = 4'b0011;
    for (int j = 0; j < 3; j++) begin
      tick(1);
      check("held_grant", 32'(gnt), 1 << held_winner(j));
      expect_done(4'(1 << held_winner(j)), 4'd0);
      tick(1);
      if (j == 2) req = '0;
      tick(1);
      check("held_idle", 32'({done, busy}), 0);
    end

    tick(2);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/contador_sched.md
Name: contador_sched

Overview:
- Scheduler/controller for the shared 4-bit counter datapath.
- Arbitrates N_REQ requesters, each asking for a counting job "count from 0 up to target".
- Grants the counter to one requester at a time, sequences it and signals job completion.
- Round-robin by default; fixed priority when the optional macro is defined. Sits between the requester blocks and the counter.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- CNT_W, 4, counter width in bits

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  N_REQ  level request per requester; held until done or abort
- tgt  input  N_REQ*CNT_W  flattened targets; requester i uses bits [i*CNT_W +: CNT_W]
- gnt  output  N_REQ  one-hot grant, high while the job runs
- done  output  N_REQ  one-cycle completion pulse to the job owner
- contador  output  CNT_W  shared counter value
- busy  output  1  high in any state except IDLE

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-high (reset).
- All outputs are registered.
- Reset values: gnt=0, done=0, contador=0, busy=0, state=IDLE, RR pointer = requester 0 highest priority.
- Reset asserted mid-job aborts immediately. No done pulse. All values return to the reset values above.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If req != 0: pick winner w by round-robin, starting at index (last_winner+1) mod N_REQ.
  - Latch tgt[w] into an internal register; contador <= 0; gnt[w] <= 1; busy <= 1; go to COUNT.
  - If req == 0: stay in IDLE; contador holds its value.
- COUNT:
  - If req[w]==0 (abort): next state IDLE; gnt <= 0; no done pulse; contador holds; RR pointer still advances past w.
  - Else if contador == latched target: next state DONE; gnt <= 0; done[w] <= 1.
  - Else: contador <= contador + 1.
- DONE: done <= 0; busy <= 0; next state IDLE. contador holds the target value.
- Timing: req rises with state IDLE at cycle T.
  - gnt[w]=1 and contador=0 at T+1 (cycle G).
  - contador=k at G+k.
  - done[w]=1 for exactly one cycle at G+t+1, where t is the target.
  - busy=0 and state IDLE at G+t+2.
  - Next grant visible at G+t+3 at the earliest.
- Target is latched at grant. Changes to tgt during a job are ignored.
- Target 0: done at G+1; contador stays 0.
- Target 2^CNT_W-1 (15): contador reaches 15 with no wrap. Arithmetic is modulo 2^CNT_W, but wrap is unreachable.
- Requester protocol: drop req in the cycle after observing done. A req still high in IDLE is treated as a new job; RR ordering gives others precedence.
- Simultaneous requests are resolved only in IDLE. New req edges during COUNT wait.
- Invariants: gnt is one-hot or zero; done is one-hot or zero; gnt and done are never both high.

Optional Feature:
- Macro: CONTADOR_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the RR pointer is removed.
- Undefined: round-robin as described above.
- Ports and timing are identical in both builds.

Test Plan:
- Reset mid-job: reset high while contador=3 in COUNT -> gnt=0, done=0, contador=0, busy=0 asynchronously; after release, req[0] is granted first.
- Single job: req=4'b0001, tgt[3:0]=5 -> gnt[0] high for 6 cycles with contador 0..5; done[0] pulses once 6 cycles after gnt rises; busy low 1 cycle later.
- Boundary targets:
  - tgt=0 -> done one cycle after gnt, contador stays 0.
  - tgt=15 -> contador reaches 15 with no wrap, done after 16 gnt cycles.
- Round-robin: req=4'b1111 with all tgt=1, each requester dropping req after its done -> grant order 0,1,2,3.
  - With CONTADOR_SCHED_FIXED_PRIO_EN and req held: requester 0 is re-granted after every job.
- Abort: req[2] drops while contador=2, tgt=9 -> gnt=0 next cycle, no done, contador holds 2, state returns to IDLE.
- Target change ignored: tgt[1] changed from 7 to 3 during the job -> done still arrives when contador=7.
